// File: rtl/encode_match_ctl.sv
// LZF encode match controller: classifies each input byte as literal or hash hit,
// extends hits against the history buffer and hands out one token at a time.
//
// state  | meaning
// IDLE   | waiting for the first byte of a stream
// CHECK  | testing each byte's hash candidate; misses become literal tokens
// EXTEND | following a hit through history, growing len per matching byte
// EMIT   | match token out, literal for the breaking byte waits behind it
// DONE   | end of stream; drains the token register, then flags done
module encode_match_ctl #(
  parameter int LZF_WIDTH = 20,
  parameter int MAX_LEN   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           data,
  input  logic                 data_valid,
  input  logic                 data_empty,
  input  logic [7:0]           hash_data,
  input  logic [7:0]           hash_data1,
  input  logic [LZF_WIDTH-1:0] hash_ref,
  input  logic [7:0]           data_d1,
  input  logic [7:0]           data_d2,
  input  logic [LZF_WIDTH-1:0] iidx,
  input  logic [7:0]           hdata,
  input  logic                 tok_full,
  output logic [10:0]          hraddr,
  output logic                 stall,
  output logic                 tok_valid,
  output logic                 tok_type,
  output logic [7:0]           tok_lit,
  output logic [10:0]          tok_off,
  output logic [7:0]           tok_len,
  output logic                 done
);

  typedef enum logic [2:0] {IDLE, CHECK, EXTEND, EMIT, DONE} state_t;

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t               state;
  logic [7:0]           len;
  logic [10:0]          off;
  logic [7:0]           lit_pend;
  logic                 eos_pend;

  logic [LZF_WIDTH-1:0] off_full;
  logic                 hit;
  logic                 act;
  logic                 tok_take;
  logic                 ext_match;
  logic [7:0]           len_inc;

  logic                 ld;
  logic                 ld_type;
  logic [7:0]           ld_lit;
  logic [10:0]          ld_off;
  logic [7:0]           ld_len;

  // Offsets wrap modulo the index width; only 1..2047 fits the 11-bit window.
  assign off_full  = iidx - hash_ref;
  assign hit       = ({hash_data1, hash_data} == {data_d2, data_d1}) &&
                     (off_full != '0) && ((off_full >> 11) == '0);
  assign stall     = (tok_valid && tok_full) || (state == EMIT) || (state == DONE);
  assign act       = data_valid && !stall;
  assign tok_take  = tok_valid && !tok_full;
  assign ext_match = (hdata == data);
  assign len_inc   = len + 8'd1;

  always_comb begin
    ld      = 1'b0;
    ld_type = 1'b0;
    ld_lit  = 8'd0;
    ld_off  = 11'd0;
    ld_len  = 8'd0;
    case (state)
      IDLE, CHECK: begin
        if (act) begin
          // A hit arriving with end-of-stream is flushed as a two-byte match.
          ld      = !hit || data_empty;
          ld_type = hit;
          ld_lit  = hit ? 8'd0 : data_d1;
          ld_off  = hit ? off_full[10:0] : 11'd0;
          ld_len  = hit ? 8'd2 : 8'd0;
        end
      end
      EXTEND: begin
        if (act) begin
          ld      = !ext_match || (len_inc == MAX_LEN_B) || data_empty;
          ld_type = 1'b1;
          ld_off  = off;
          ld_len  = ext_match ? len_inc : len;
        end else if (data_empty && !stall) begin
          ld      = 1'b1;
          ld_type = 1'b1;
          ld_off  = off;
          ld_len  = len;
        end
      end
      EMIT: begin
        if (tok_take) begin
          ld     = 1'b1;
          ld_lit = lit_pend;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      len       <= 8'd0;
      off       <= 11'd0;
      lit_pend  <= 8'd0;
      eos_pend  <= 1'b0;
      hraddr    <= 11'd0;
      tok_valid <= 1'b0;
      tok_type  <= 1'b0;
      tok_lit   <= 8'd0;
      tok_off   <= 11'd0;
      tok_len   <= 8'd0;
      done      <= 1'b0;
    end else begin
      if (ld) begin
        tok_valid <= 1'b1;
        tok_type  <= ld_type;
        tok_lit   <= ld_lit;
        tok_off   <= ld_off;
        tok_len   <= ld_len;
      end else if (tok_take) begin
        tok_valid <= 1'b0;
      end

      case (state)
        IDLE, CHECK: begin
          if (act) begin
            if (hit) begin
              off    <= off_full[10:0];
              len    <= 8'd2;
              hraddr <= hash_ref[10:0] + 11'd2;
              state  <= data_empty ? DONE : EXTEND;
            end else begin
              state  <= data_empty ? DONE : CHECK;
            end
          end else if (data_empty && !stall) begin
            state <= DONE;
            if (!tok_valid || tok_take) done <= 1'b1;
          end
        end
        EXTEND: begin
          if (act) begin
            if (ext_match) begin
              len    <= len_inc;
              hraddr <= hraddr + 11'd1;
              if (data_empty)                  state <= DONE;
              else if (len_inc == MAX_LEN_B)   state <= CHECK;
            end else begin
              lit_pend <= data;
              eos_pend <= data_empty;
              state    <= EMIT;
            end
          end else if (data_empty && !stall) begin
            state <= DONE;
          end
        end
        EMIT: begin
          if (tok_take) state <= eos_pend ? DONE : CHECK;
        end
        DONE: begin
          if (!tok_valid || tok_take) done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encode_match_ctl.sv
// Scoreboard bench for encode_match_ctl: streams are planned as literal/match
// segments, expected tokens follow from the plan, a monitor checks accepted tokens.
module tb_encode_match_ctl;
  localparam int W    = 20;
  localparam int MAXL = 255;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    data = 8'd0;
  logic          data_valid = 1'b0;
  logic          data_empty = 1'b0;
  logic [7:0]    hash_data = 8'd0;
  logic [7:0]    hash_data1 = 8'd0;
  logic [W-1:0]  hash_ref = '0;
  logic [7:0]    data_d1 = 8'd0;
  logic [7:0]    data_d2 = 8'd0;
  logic [W-1:0]  iidx = '0;
  logic [7:0]    hdata = 8'd0;
  logic          tok_full = 1'b0;
  logic [10:0]   hraddr;
  logic          stall;
  logic          tok_valid;
  logic          tok_type;
  logic [7:0]    tok_lit;
  logic [10:0]   tok_off;
  logic [7:0]    tok_len;
  logic          done;

  always #5 clk = ~clk;

  encode_match_ctl #(.LZF_WIDTH(W), .MAX_LEN(MAXL)) dut (
    .clk(clk), .rst(rst), .data(data), .data_valid(data_valid), .data_empty(data_empty),
    .hash_data(hash_data), .hash_data1(hash_data1), .hash_ref(hash_ref),
    .data_d1(data_d1), .data_d2(data_d2), .iidx(iidx), .hdata(hdata), .tok_full(tok_full),
    .hraddr(hraddr), .stall(stall), .tok_valid(tok_valid), .tok_type(tok_type),
    .tok_lit(tok_lit), .tok_off(tok_off), .tok_len(tok_len), .done(done)
  );

  int          compared = 0;
  int          mism     = 0;
  int          cyc      = 0;
  int          acc_cyc  = 0;
  bit          bp_on    = 1'b0;
  logic        done_q   = 1'b0;
  logic [27:0] expq[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [27:0] lit_tok(input logic [7:0] b);
    return {1'b0, b, 11'd0, 8'd0};
  endfunction

  function automatic logic [27:0] mat_tok(input logic [10:0] o, input int l);
    return {1'b1, 8'd0, o, 8'(l)};
  endfunction

  // Monitor: a token is taken on each edge where tok_valid is high and tok_full low.
  always @(negedge clk) begin
    logic [27:0] got, e;
    if (rst) begin
      assert (!(data_valid && stall)) else begin
        mism++;
        $display("FAIL protocol: data_valid presented while stall high at cycle %0d", cyc);
      end
      if (tok_valid && !tok_full) begin
        got = {tok_type, tok_lit, tok_off, tok_len};
        compared++;
        if (expq.size() == 0) begin
          mism++;
          $display("FAIL token_unexpected: got type=%0d lit=%02h off=%0d len=%0d, none expected",
                   got[27], got[26:19], got[18:8], got[7:0]);
        end else begin
          e = expq.pop_front();
          if (got !== e) begin
            mism++;
            $display("FAIL token: got type=%0d lit=%02h off=%0d len=%0d, expected type=%0d lit=%02h off=%0d len=%0d",
                     got[27], got[26:19], got[18:8], got[7:0], e[27], e[26:19], e[18:8], e[7:0]);
          end
        end
        acc_cyc = cyc;
      end
      if (done && !done_q) begin
        compared++;
        if (cyc != acc_cyc + 1) begin
          mism++;
          $display("FAIL done_latency: rose in cycle %0d, expected cycle %0d", cyc, acc_cyc + 1);
        end
      end
    end
    done_q = done;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mism++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    mism++;
    $display("FAIL %s: timed out waiting on DUT", nm);
    $fatal(1, "bench aborted");
  endtask

  task automatic set_bp();
    tok_full = bp_on && ($urandom_range(0, 3) == 0);
  endtask

  // Entered and left at posedge+1; holds off until the DUT stops stalling.
  task automatic wait_ready();
    int guard;
    guard = 0;
    if ($urandom_range(0, 4) == 0) begin
      @(posedge clk); #1;
    end
    set_bp(); #1;
    while (stall) begin
      @(posedge clk); #1;
      set_bp(); #1;
      guard++;
      if (guard > 1000) timeout("wait_ready");
    end
  endtask

  task automatic drive_cycle(input logic [7:0] d, input logic [7:0] d1, input logic [7:0] d2,
                             input logic [7:0] hd, input logic [7:0] h0, input logic [7:0] h1,
                             input logic [W-1:0] ix, input logic [W-1:0] hr, input bit emp);
    wait_ready();
    data = d; data_d1 = d1; data_d2 = d2; hdata = hd;
    hash_data = h0; hash_data1 = h1; iidx = ix; hash_ref = hr;
    data_valid = 1'b1;
    data_empty = emp;
    @(posedge clk); #1;
    data_valid = 1'b0;
  endtask

  task automatic eos_alone();
    wait_ready();
    data_empty = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_literal(input logic [7:0] b, input bit emp);
    logic [W-1:0] ix, hr;
    logic [7:0]   d2, h0;
    ix = W'($urandom);
    d2 = 8'($urandom);
    h0 = b;
    case ($urandom_range(0, 2))
      0:       begin h0 = ~b; hr = ix - W'($urandom_range(1, 2047)); end
      1:       hr = ix;
      default: hr = ix - W'($urandom_range(2048, 600000));
    endcase
    drive_cycle(8'($urandom), b, d2, 8'($urandom), h0, d2, ix, hr, emp);
    expq.push_back(lit_tok(b));
  endtask

  // term: 0 mismatch byte, 1 eos on last matching byte, 2 eos alone,
  //       3 run capped at MAXL, 4 mismatch byte with eos, 5 left pending
  task automatic do_match(input logic [W-1:0] ix, input logic [10:0] o, input int l,
                          input int term, input logic [7:0] mm);
    logic [W-1:0] hr;
    logic [10:0]  ha;
    logic [7:0]   d1, d2, b;
    d1 = 8'($urandom);
    d2 = 8'($urandom);
    hr = ix - {9'd0, o};
    drive_cycle(8'($urandom), d1, d2, 8'($urandom), d1, d2, ix, hr, (term == 1) && (l == 2));
    ha = hr[10:0] + 11'd2;
    for (int k = 0; k < l - 2; k++) begin
      chk("hraddr_extend", 32'(hraddr), 32'(ha));
      b = 8'($urandom);
      drive_cycle(b, 8'($urandom), 8'($urandom), b, 8'($urandom), 8'($urandom),
                  ix + W'(k + 1), W'($urandom), (term == 1) && (k == l - 3));
      ha = ha + 11'd1;
    end
    case (term)
      0, 4: begin
        chk("hraddr_mismatch", 32'(hraddr), 32'(ha));
        drive_cycle(mm, 8'($urandom), 8'($urandom), ~mm, 8'($urandom), 8'($urandom),
                    ix + W'(l), W'($urandom), term == 4);
        expq.push_back(mat_tok(o, l));
        expq.push_back(lit_tok(mm));
      end
      1, 3: expq.push_back(mat_tok(o, l));
      2: begin
        chk("hraddr_eos", 32'(hraddr), 32'(ha));
        eos_alone();
        expq.push_back(mat_tok(o, l));
      end
      default: ;
    endcase
  endtask

  task automatic apply_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_hraddr", 32'(hraddr), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_tok_valid", 32'(tok_valid), 32'd0);
    chk("rst_tok_type", 32'(tok_type), 32'd0);
    chk("rst_tok_lit", 32'(tok_lit), 32'd0);
    chk("rst_tok_off", 32'(tok_off), 32'd0);
    chk("rst_tok_len", 32'(tok_len), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    data_valid = 1'b0;
    data_empty = 1'b0;
    tok_full   = 1'b0;
    expq.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic finish_stream();
    int guard;
    guard = 0;
    while (!done && guard < 2000) begin
      @(posedge clk); #1;
      set_bp();
      guard++;
    end
    chk("done_reached", 32'(done), 32'd1);
    chk("queue_drained", 32'(expq.size()), 32'd0);
    @(posedge clk); #1;
    apply_reset();
  endtask

  task automatic rand_stream(input int nseg);
    bit last;
    int l, term;
    for (int s = 0; s < nseg; s++) begin
      last = (s == nseg - 1);
      if ($urandom_range(0, 9) < 5) begin
        do_literal(8'($urandom), last);
      end else begin
        l = ($urandom_range(0, 19) == 0) ? MAXL : $urandom_range(2, 12);
        if (l == MAXL)  term = last ? 1 : 3;
        else if (last)  term = ($urandom_range(0, 2) == 0) ? 4 : $urandom_range(1, 2);
        else            term = 0;
        do_match(W'($urandom), 11'($urandom_range(1, 2047)), l, term, 8'($urandom));
      end
    end
    finish_stream();
  endtask

  initial begin
    int guard;
    #3;
    chk("por_tok_valid", 32'(tok_valid), 32'd0);
    chk("por_stall", 32'(stall), 32'd0);
    chk("por_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed stream: literals, backpressure hold, offsets, wrap, cap, eos in EXTEND.
    bp_on = 1'b0;
    do_literal(8'h41, 1'b0);
    tok_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_stall", 32'(stall), 32'd1);
      chk("hold_valid", 32'(tok_valid), 32'd1);
      chk("hold_lit", 32'(tok_lit), 32'h41);
      @(posedge clk); #1;
    end
    tok_full = 1'b0;
    do_literal(8'h42, 1'b0);
    do_literal(8'h43, 1'b0);
    do_match(W'(100), 11'd10, 5, 0, 8'h5A);
    do_match(W'(2051), 11'd5, 6, 0, 8'h33);
    do_match(W'($urandom), 11'd700, MAXL, 3, 8'h00);
    for (int i = 0; i < 5; i++) do_literal(8'($urandom), 1'b0);
    do_match(W'($urandom), 11'd2047, 7, 2, 8'h00);
    finish_stream();

    // Randomised streams with random backpressure.
    bp_on = 1'b1;
    for (int n = 0; n < 6; n++) rand_stream($urandom_range(8, 16));

    // Reset in the middle of a match must drop it.
    do_literal(8'($urandom), 1'b0);
    do_match(W'($urandom), 11'd33, 6, 5, 8'h00);
    guard = 0;
    while (expq.size() != 0 && guard < 100) begin
      tok_full = 1'b0;
      @(posedge clk); #1;
      guard++;
    end
    chk("abort_drained", 32'(expq.size()), 32'd0);
    apply_reset();
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_token", 32'(tok_valid), 32'd0);
    chk("abort_hraddr", 32'(hraddr), 32'd0);
    rand_stream(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule

// File: doc/encode_match_ctl.md
ENCODE_MATCH_CTL -- requirements
Module: encode_match_ctl

Interface
REQ-001 SHALL have parameter LZF_WIDTH, default 20, width of byte index and hash reference.
REQ-002 SHALL have parameter MAX_LEN, default 255, longest match length emitted in one token.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port data  input  8  current input byte from encode datapath.
REQ-006 SHALL have port data_valid  input  1  data qualifier, one byte per asserted cycle.
REQ-007 SHALL have port data_empty  input  1  end of stream, no further bytes.
REQ-008 SHALL have ports hash_data, hash_data1  input  8 each  candidate bytes from hash table.
REQ-009 SHALL have port hash_ref  input  LZF_WIDTH  byte index of candidate.
REQ-010 SHALL have ports data_d1, data_d2  input  8 each  previous two input bytes.
REQ-011 SHALL have port iidx  input  LZF_WIDTH  index of current byte.
REQ-012 SHALL have port hdata  input  8  history read data, one cycle after hraddr.
REQ-013 SHALL have port tok_full  input  1  downstream token sink full.
REQ-014 SHALL have port hraddr  output  11  history read address.
REQ-015 SHALL have port stall  output  1  drives datapath fo_full; upstream holds bytes while high.
REQ-016 SHALL have ports tok_valid 1, tok_type 1 (0 literal, 1 match), tok_lit 8, tok_off 11, tok_len 8  outputs  token register.
REQ-017 SHALL have port done  output  1  stream fully tokenised.

Function
REQ-018 SHALL implement states IDLE, CHECK, EXTEND, EMIT, DONE.
REQ-019 IDLE SHALL go to CHECK on first data_valid; byte is treated as CHECK input in same cycle.
REQ-020 CHECK: candidate hit SHALL be {hash_data1,hash_data}=={data_d2,data_d1} AND off=iidx-hash_ref (modulo 2^LZF_WIDTH) in 1..2047.
REQ-021 CHECK miss SHALL load literal token for data_d1, stay in CHECK.
REQ-022 CHECK hit SHALL latch off, set len=2, drive hraddr=hash_ref[10:0]+2 (mod 2048), go to EXTEND.
REQ-023 EXTEND: per data_valid, hdata==data SHALL increment len and hraddr by 1 (hraddr wraps 2047->0).
REQ-024 EXTEND mismatch SHALL emit match token (off,len) then literal token for mismatching byte, return to CHECK.
REQ-025 len reaching MAX_LEN SHALL emit match token immediately and return to CHECK.
REQ-026 Token register SHALL be single-entry; tok_valid held with fields stable until cycle with tok_full low, then cleared.
REQ-027 stall SHALL be high when tok_valid&tok_full, in EMIT (two-token sequence), or in DONE.
REQ-028 Bytes with data_valid while stall high SHALL be a protocol violation (bench assertion), not handled.
REQ-029 data_empty in CHECK SHALL go to DONE after last token accepted; in EXTEND SHALL emit pending match first.
REQ-030 data_empty and data_valid same cycle SHALL process the byte first, then end-of-stream.
REQ-031 done SHALL assert one cycle after final token accepted, remain high until reset.
REQ-032 Token latency SHALL be 1 cycle from deciding data_valid edge to tok_valid.

Reset
REQ-033 On rst low: state IDLE, hraddr 0, stall 0, tok_valid 0, tok_type 0, tok_lit 0, tok_off 0, tok_len 0, done 0, len 0, asynchronously.
REQ-034 rst asserted mid-EXTEND SHALL discard pending match; no token emitted after rst release until new data_valid.

Verification
REQ-035 Bytes 0x41,0x42,0x43 with no hash hit -> three literal tokens 0x41,0x42,0x43, tok_type 0.
REQ-036 Hit at iidx=100, hash_ref=90, then 3 matching hdata, then mismatch 0x5A -> match off=10 len=5, literal 0x5A.
REQ-037 Hit with hash_ref[10:0]=2046, 4 extensions -> hraddr sequence 0,1,2,3,4 (wrap), len=6.
REQ-038 260 matching bytes -> match len=255 token, then CHECK resumes; no byte lost.
REQ-039 tok_full held 5 cycles with tok_valid -> stall high 5 cycles, token fields unchanged, accepted on release.
REQ-040 data_empty during EXTEND len=7 -> match len=7 emitted, done high next cycle after acceptance; rst low then -> all outputs 0.
